// File: rtl/gpio_button_scanner.sv
// Tile push-button front end: polarity fix, two-FF sync, per-bit debounce, and a
// lowest-index arbiter producing a registered one-hot guess. BTN_PRESS_COUNT_EN adds press_count.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for an enabled debounced press
// S_HELD    | guess latched, held until that button releases or enable drops
// S_RELEASE | outputs cleared, waiting for every button to be released
module gpio_button_scanner #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_raw,
    input  logic         enable,
    output logic [N-1:0] guess,
    output logic         guess_valid,
    output logic         press_pulse,
    output logic         busy
`ifdef BTN_PRESS_COUNT_EN
    ,
    output logic [7:0]   press_count
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N-1:0] POL_MASK = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HELD    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  pressed;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  db;
    logic [CW-1:0] cnt [N];
    logic [N-1:0]  lowest;

    assign pressed = btn_raw ^ POL_MASK;
    // Two's-complement trick isolates the lowest set bit of db.
    assign lowest  = db & (~db + N'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pressed;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            guess       <= '0;
            guess_valid <= 1'b0;
            press_pulse <= 1'b0;
            busy        <= 1'b0;
`ifdef BTN_PRESS_COUNT_EN
            press_count <= 8'd0;
`endif
        end else begin
            press_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && (db != '0)) begin
                        guess       <= lowest;
                        guess_valid <= 1'b1;
                        press_pulse <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_HELD;
`ifdef BTN_PRESS_COUNT_EN
                        press_count <= press_count + 8'd1;
`endif
                    end
                end
                S_HELD: begin
                    if (((db & guess) == '0) || !enable) begin
                        guess       <= '0;
                        guess_valid <= 1'b0;
                        state       <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (db == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    guess       <= '0;
                    guess_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_button_scanner.sv
// Directed bench for gpio_button_scanner with DEBOUNCE_CYCLES=4, active-low buttons.
// Press-to-output latency is 7 edges from the edge after which btn_raw changes.
module tb_gpio_button_scanner;

    logic       clk;
    logic       reset;
    logic [7:0] btn_raw;
    logic       enable;
    logic [7:0] guess;
    logic       guess_valid;
    logic       press_pulse;
    logic       busy;
`ifdef BTN_PRESS_COUNT_EN
    logic [7:0] press_count;
`endif

    int checks;
    int fails;
    int pulse_total;
    logic prev_pulse;

    gpio_button_scanner #(
        .N(8),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .enable(enable),
        .guess(guess),
        .guess_valid(guess_valid),
        .press_pulse(press_pulse),
        .busy(busy)
`ifdef BTN_PRESS_COUNT_EN
        ,
        .press_count(press_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_pulse) begin
            pulse_total++;
            checks++;
            if (prev_pulse) begin
                fails++;
                $display("FAIL pulse_back_to_back: press_pulse high on two consecutive cycles, want single cycle");
            end
        end
        prev_pulse = press_pulse;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        btn_raw = 8'hFF;
        enable  = 1'b1;
        #1;
        checks++;
        if ({guess, guess_valid, press_pulse, busy} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got guess=%h valid=%b pulse=%b busy=%b want all 0",
                     guess, guess_valid, press_pulse, busy);
        end
        step(2);
        reset = 1'b1;
        step(3);
        checks++;
        if ({guess, guess_valid, busy} !== 10'd0) begin
            fails++;
            $display("FAIL idle_after_reset: got guess=%h valid=%b busy=%b want 0", guess, guess_valid, busy);
        end
    endtask

    task automatic test_single_press();
        btn_raw = 8'hFB;
        step(6);
        checks++;
        if (guess_valid !== 1'b0 || press_pulse !== 1'b0) begin
            fails++;
            $display("FAIL single_early: got valid=%b pulse=%b want 0 0", guess_valid, press_pulse);
        end
        step(1);
        checks++;
        if (guess !== 8'h04 || guess_valid !== 1'b1 || press_pulse !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_accept: got guess=%h valid=%b pulse=%b busy=%b want 04 1 1 1",
                     guess, guess_valid, press_pulse, busy);
        end
        step(1);
        checks++;
        if (press_pulse !== 1'b0 || guess !== 8'h04) begin
            fails++;
            $display("FAIL single_hold: got pulse=%b guess=%h want 0 04", press_pulse, guess);
        end
        btn_raw = 8'hFF;
        step(7);
        checks++;
        if (guess !== 8'h00 || guess_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_release: got guess=%h valid=%b busy=%b want 00 0 1", guess, guess_valid, busy);
        end
        step(1);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulse_total;
        btn_raw = 8'hFE;
        step(3);
        btn_raw = 8'hFF;
        step(2);
        btn_raw = 8'hFE;
        step(6);
        checks++;
        if (guess_valid !== 1'b0 || guess !== 8'h00) begin
            fails++;
            $display("FAIL bounce_early: got valid=%b guess=%h want 0 00", guess_valid, guess);
        end
        step(1);
        checks++;
        if (guess !== 8'h01 || press_pulse !== 1'b1) begin
            fails++;
            $display("FAIL bounce_accept: got guess=%h pulse=%b want 01 1", guess, press_pulse);
        end
        step(1);
        checks++;
        if ((pulse_total - p0) !== 1) begin
            fails++;
            $display("FAIL bounce_pulses: got %0d pulses want 1", pulse_total - p0);
        end
        btn_raw = 8'hFF;
        step(8);
        checks++;
        if (busy !== 1'b0 || guess !== 8'h00) begin
            fails++;
            $display("FAIL bounce_idle: got busy=%b guess=%h want 0 00", busy, guess);
        end
    endtask

    task automatic test_simultaneous();
        int p0;
        p0 = pulse_total;
        btn_raw = 8'hD7;
        step(7);
        checks++;
        if (guess !== 8'h08 || press_pulse !== 1'b1) begin
            fails++;
            $display("FAIL simul_accept: got guess=%h pulse=%b want 08 1", guess, press_pulse);
        end
        btn_raw = 8'hDF;
        step(7);
        checks++;
        if (guess !== 8'h00 || guess_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL simul_release3: got guess=%h valid=%b busy=%b want 00 0 1", guess, guess_valid, busy);
        end
        step(4);
        checks++;
        if (busy !== 1'b1 || guess !== 8'h00 || (pulse_total - p0) !== 1) begin
            fails++;
            $display("FAIL simul_wait_release: got busy=%b guess=%h pulses=%0d want 1 00 1",
                     busy, guess, pulse_total - p0);
        end
        btn_raw = 8'hFF;
        step(7);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL simul_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_enable();
        enable  = 1'b0;
        btn_raw = 8'hFD;
        step(10);
        checks++;
        if (guess_valid !== 1'b0 || guess !== 8'h00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL enable_blocked: got valid=%b guess=%h busy=%b want 0 00 0", guess_valid, guess, busy);
        end
        enable = 1'b1;
        step(1);
        checks++;
        if (guess !== 8'h02 || press_pulse !== 1'b1) begin
            fails++;
            $display("FAIL enable_rise: got guess=%h pulse=%b want 02 1", guess, press_pulse);
        end
        step(1);
        checks++;
        if (press_pulse !== 1'b0 || guess_valid !== 1'b1) begin
            fails++;
            $display("FAIL enable_hold: got pulse=%b valid=%b want 0 1", press_pulse, guess_valid);
        end
        enable = 1'b0;
        step(1);
        checks++;
        if (guess !== 8'h00 || guess_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL enable_drop: got guess=%h valid=%b busy=%b want 00 0 1", guess, guess_valid, busy);
        end
        btn_raw = 8'hFF;
        step(8);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL enable_idle: got busy=%b want 0", busy);
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        btn_raw = 8'hBF;
        step(7);
        checks++;
        if (guess !== 8'h40 || guess_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_held: got guess=%h valid=%b want 40 1", guess, guess_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (guess !== 8'h00 || guess_valid !== 1'b0 || busy !== 1'b0 || press_pulse !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: got guess=%h valid=%b busy=%b pulse=%b want 00 0 0 0",
                     guess, guess_valid, busy, press_pulse);
        end
        step(1);
        reset = 1'b1;
        step(6);
        checks++;
        if (guess_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_redebounce_early: got valid=%b want 0", guess_valid);
        end
        step(1);
        checks++;
        if (guess !== 8'h40 || guess_valid !== 1'b1 || press_pulse !== 1'b1) begin
            fails++;
            $display("FAIL rst_reaccept: got guess=%h valid=%b pulse=%b want 40 1 1", guess, guess_valid, press_pulse);
        end
        btn_raw = 8'hFF;
        step(8);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_idle: got busy=%b want 0", busy);
        end
    endtask

`ifdef BTN_PRESS_COUNT_EN
    task automatic test_press_count();
        int p0;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(2);
        checks++;
        if (press_count !== 8'd0) begin
            fails++;
            $display("FAIL count_reset: got %0d want 0", press_count);
        end
        p0 = pulse_total;
        for (int i = 0; i < 257; i++) begin
            btn_raw = 8'hFE;
            step(7);
            btn_raw = 8'hFF;
            step(8);
        end
        checks++;
        if (press_count !== 8'd1 || (pulse_total - p0) !== 257) begin
            fails++;
            $display("FAIL count_wrap: got count=%0d pulses=%0d want 1 257", press_count, pulse_total - p0);
        end
    endtask
`endif

    initial begin
        checks      = 0;
        fails       = 0;
        pulse_total = 0;
        prev_pulse  = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_enable();
        test_async_reset();
`ifdef BTN_PRESS_COUNT_EN
        test_press_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
